// File: rtl/clock_defs_pkg.sv
// Shared definitions for the pushbutton time-setting controller: edit states,
// BCD digit type, field limits, time-word slices and BCD stepping helpers.
package clock_defs_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_H,
    SET_M,
    SET_S,
    COMMIT
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int HOURS_MAX  = 23;
  localparam int MINSEC_MAX = 59;

  localparam int TIME_W   = 24;
  localparam int FIELD_W  = 8;
  localparam int HOUR_LSB = 16;
  localparam int MIN_LSB  = 8;
  localparam int SEC_LSB  = 0;

  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Steps a two-digit BCD field by one, wrapping between 00 and max (max in BCD).
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] max,
                                          input logic up);
    bcd_digit_t hi;
    bcd_digit_t lo;
    hi = v[7:4];
    lo = v[3:0];
    if (up) begin
      if (v == max) return 8'h00;
      if (lo == 4'd9) return {hi + 4'd1, 4'd0};
      return {hi, lo + 4'd1};
    end else begin
      if (v == 8'h00) return max;
      if (lo == 4'd0) return {hi - 4'd1, 4'd9};
      return {hi, lo - 4'd1};
    end
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw button: 2-FF synchroniser, debounce counter and a registered press pulse.
// With AUTO_REPEAT_EN defined, a held level adds repeat pulses.
module button_debouncer
  import clock_defs_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rpt_fire;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  logic [RW-1:0] rpt_q, rpt_d;

  // After the first repeat the timer reloads so later repeats come every REPEAT_RATE.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (level_q) begin
      if (rpt_q == RW'(REPEAT_DELAY - 1)) begin
        rpt_fire = 1'b1;
        rpt_d    = RW'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        rpt_d = rpt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rpt_q <= '0;
    else       rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign press_d = (level_q & ~dly_q) | rpt_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      dly_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      dly_q   <= level_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_time_setter.sv
// Pushbutton time-entry controller: edits a shadow HH:MM:SS BCD word and commits it
// with a one-cycle load strobe. Optional auto-repeat via macro AUTO_REPEAT_EN.
module clock_time_setter
  import clock_defs_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_DIV       = 25_000_000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [TIME_W-1:0] cur_time,
  output logic [TIME_W-1:0] set_time,
  output logic              load,
  output logic              setting,
  output logic [5:0]        blank_mask
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic mode_p, up_p, down_p;

  state_e              state_q, state_d;
  logic [TIME_W-1:0]   set_time_q, set_time_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [FIELD_W-1:0]  edit_val, edit_max;
  logic                edit_en;
  int unsigned         edit_lsb;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
`endif
  ) u_db_mode (.clk_i(clock), .rst_i(reset), .btn_i(btn_mode), .press_o(mode_p));

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
`endif
  ) u_db_up (.clk_i(clock), .rst_i(reset), .btn_i(btn_up), .press_o(up_p));

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
`endif
  ) u_db_down (.clk_i(clock), .rst_i(reset), .btn_i(btn_down), .press_o(down_p));

  always_comb begin
    edit_en  = 1'b1;
    edit_lsb = SEC_LSB;
    edit_max = to_bcd8(MINSEC_MAX);
    case (state_q)
      SET_H: begin
        edit_lsb = HOUR_LSB;
        edit_max = to_bcd8(HOURS_MAX);
      end
      SET_M:   edit_lsb = MIN_LSB;
      SET_S:   edit_lsb = SEC_LSB;
      default: edit_en  = 1'b0;
    endcase
    edit_val = set_time_q[edit_lsb +: FIELD_W];
  end

  always_comb begin
    state_d    = state_q;
    set_time_d = set_time_q;
    phase_d    = phase_q;
    blink_cnt_d = blink_cnt_q + BW'(1);
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    // A mode press outranks any simultaneous edit; up+down together cancel.
    if (mode_p) begin
      case (state_q)
        RUN: begin
          state_d     = SET_H;
          set_time_d  = cur_time;
          blink_cnt_d = '0;
          phase_d     = 1'b0;
        end
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        SET_S:   state_d = COMMIT;
        default: state_d = RUN;
      endcase
    end else begin
      if (state_q == COMMIT) state_d = RUN;
      if (edit_en && (up_p ^ down_p)) begin
        set_time_d[edit_lsb +: FIELD_W] = bcd_step(edit_val, edit_max, up_p);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      set_time_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_time_q  <= set_time_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    blank_mask = '0;
    if (phase_q) begin
      case (state_q)
        SET_H:   blank_mask = 6'b110000;
        SET_M:   blank_mask = 6'b001100;
        SET_S:   blank_mask = 6'b000011;
        default: blank_mask = '0;
      endcase
    end
  end

  assign set_time = set_time_q;
  assign load     = (state_q == COMMIT);
  assign setting  = (state_q != RUN);

endmodule

// File: tb/tb_clock_time_setter.sv
// Self-checking bench for clock_time_setter: directed scenarios plus randomized edit
// sessions compared against an integer-arithmetic model of the time being set.
module tb_clock_time_setter;

  localparam int DEB   = 4;
  localparam int BLINK = 8;
`ifdef AUTO_REPEAT_EN
  localparam int RDLY  = 20;
  localparam int RRATE = 5;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [23:0] cur_time = '0;
  logic [23:0] set_time;
  logic        load;
  logic        setting;
  logic [5:0]  blank_mask;

  clock_time_setter #(
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_DIV(BLINK)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
`endif
  ) dut (
    .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down), .cur_time(cur_time), .set_time(set_time), .load(load),
    .setting(setting), .blank_mask(blank_mask)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integers for the live clock and the shadow copy.
  int ch, cm, cs;
  int mh, mm, ms;
  int fld = 0;             // 0 idle, 1 hours, 2 minutes, 3 seconds
  int exp_loads = 0;
  logic [23:0] exp_load_val = '0;

  int          load_cnt = 0;
  logic [23:0] load_val = '0;
  logic        load_setting = 1'b0;

  always @(negedge clock) begin
    if (load) begin
      load_cnt++;
      load_val     = set_time;
      load_setting = setting;
    end
  end

  function automatic logic [23:0] pack(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [5:0] field_mask(input int f);
    case (f)
      1:       return 6'b110000;
      2:       return 6'b001100;
      3:       return 6'b000011;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    ch = h; cm = m; cs = s;
    cur_time = pack(h, m, s);
  endtask

  task automatic apply_step(input bit up);
    case (fld)
      1: mh = up ? (mh + 1) % 24 : (mh + 23) % 24;
      2: mm = up ? (mm + 1) % 60 : (mm + 59) % 60;
      3: ms = up ? (ms + 1) % 60 : (ms + 59) % 60;
      default: ;
    endcase
  endtask

  task automatic model_press(input bit m, input bit u, input bit d);
    if (m) begin
      if (fld == 0) begin
        mh = ch; mm = cm; ms = cs; fld = 1;
      end else if (fld < 3) begin
        fld++;
      end else begin
        fld = 0;
        exp_loads++;
        exp_load_val = pack(mh, mm, ms);
      end
    end else if (u != d && fld != 0) begin
      apply_step(u);
    end
  endtask

  task automatic do_press(input bit m, input bit u, input bit d);
    btn_mode = m; btn_up = u; btn_down = d;
    cycles(10);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cycles(10);
    model_press(m, u, d);
  endtask

  task automatic check_state(input string tag);
    if (fld == 0) begin
      check({tag, "_setting"}, 32'(setting), 32'd0);
    end else begin
      check({tag, "_setting"}, 32'(setting), 32'd1);
      check({tag, "_time"}, 32'(set_time), 32'(pack(mh, mm, ms)));
    end
  endtask

  task automatic check_commit(input string tag);
    check({tag, "_loads"}, 32'(load_cnt), 32'(exp_loads));
    check({tag, "_loadval"}, 32'(load_val), 32'(exp_load_val));
    check({tag, "_loadset"}, 32'(load_setting), 32'd1);
    check({tag, "_after"}, 32'(setting), 32'd0);
  endtask

  task automatic check_blink(input string tag);
    logic [5:0] acc;
    acc = '0;
    repeat (20) begin
      @(negedge clock);
      acc |= blank_mask;
    end
    #1;
    check({tag, "_blink"}, 32'(acc), 32'(field_mask(fld)));
  endtask

  task automatic commit_from_field(input string tag);
    while (fld != 0) do_press(1'b1, 1'b0, 1'b0);
    check_commit(tag);
  endtask

  initial begin
    int k;
    int op;

    set_cur(0, 0, 0);
    cycles(3);
    check("rst_settime", 32'(set_time), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_setting", 32'(setting), 32'd0);
    check("rst_blank", 32'(blank_mask), 32'd0);
    reset = 1'b0;
    cycles(5);
    check_blink("run");

    // Bouncing up button produces a single step
    set_cur(7, 15, 30);
    do_press(1'b1, 1'b0, 1'b0);
    check_state("bnc_enter");
    btn_up = 1'b1; cycles(1);
    btn_up = 1'b0; cycles(1);
    btn_up = 1'b1; cycles(1);
    btn_up = 1'b0; cycles(1);
    btn_up = 1'b1; cycles(10);
    btn_up = 1'b0; cycles(10);
    model_press(1'b0, 1'b1, 1'b0);
    check("bnc_hours", 32'(set_time[23:16]), 32'h08);
    commit_from_field("bnc");

    // Full edit 12:34:56 -> 14:33:56
    set_cur(12, 34, 56);
    do_press(1'b1, 1'b0, 1'b0);
    check("full_capture", 32'(set_time), 32'h123456);
    check_state("full_h");
    check_blink("full_h");
    do_press(1'b0, 1'b1, 1'b0);
    do_press(1'b0, 1'b1, 1'b0);
    do_press(1'b1, 1'b0, 1'b0);
    check_blink("full_m");
    do_press(1'b0, 1'b0, 1'b1);
    check_state("full_m");
    do_press(1'b1, 1'b0, 1'b0);
    check_blink("full_s");
    do_press(1'b1, 1'b0, 1'b0);
    check_commit("full");
    check("full_value", 32'(load_val), 32'h143356);

    // Wrap boundaries
    set_cur(23, 0, 59);
    do_press(1'b1, 1'b0, 1'b0);
    do_press(1'b0, 1'b1, 1'b0);
    check("wrap_h", 32'(set_time), 32'h000059);
    do_press(1'b1, 1'b0, 1'b0);
    do_press(1'b0, 1'b0, 1'b1);
    check("wrap_m", 32'(set_time), 32'h005959);
    do_press(1'b1, 1'b0, 1'b0);
    do_press(1'b0, 1'b1, 1'b0);
    check("wrap_s", 32'(set_time), 32'h005900);
    check_state("wrap");
    commit_from_field("wrap");

    // Collisions
    set_cur(9, 9, 9);
    do_press(1'b1, 1'b0, 1'b0);
    do_press(1'b0, 1'b1, 1'b1);
    check_state("col_updown");
    do_press(1'b1, 1'b1, 1'b0);
    check_state("col_modeup");
    do_press(1'b0, 1'b1, 1'b0);
    check("col_inm", 32'(set_time), 32'h091009);
    commit_from_field("col");

    // Reset while editing minutes aborts without load
    set_cur(3, 45, 6);
    do_press(1'b1, 1'b0, 1'b0);
    do_press(1'b1, 1'b0, 1'b0);
    do_press(1'b0, 1'b1, 1'b0);
    check_state("rst_mid");
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("rstm_setting", 32'(setting), 32'd0);
    check("rstm_blank", 32'(blank_mask), 32'd0);
    check("rstm_time", 32'(set_time), 32'd0);
    cycles(2);
    reset = 1'b0;
    fld = 0;
    cycles(3);
    check("rstm_loads", 32'(load_cnt), 32'(exp_loads));
    set_cur(18, 27, 41);
    do_press(1'b1, 1'b0, 1'b0);
    check("rstm_recap", 32'(set_time), 32'h182741);
    commit_from_field("rstm");

    // Held up button: auto-repeat adds three steps when enabled
    set_cur(5, 10, 20);
    do_press(1'b1, 1'b0, 1'b0);
    btn_up = 1'b1;
    cycles(33);
    btn_up = 1'b0;
    cycles(12);
`ifdef AUTO_REPEAT_EN
    k = 4;
`else
    k = 1;
`endif
    repeat (k) apply_step(1'b1);
    check_state("hold");
    commit_from_field("hold");

    // Randomized edit sessions
    for (int sess = 0; sess < 8; sess++) begin
      set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      do_press(1'b1, 1'b0, 1'b0);
      check_state("rnd_enter");
      set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      for (int i = 0; i < 7; i++) begin
        op = $urandom_range(0, 5);
        case (op)
          0, 1: do_press(1'b0, 1'b1, 1'b0);
          2, 3: do_press(1'b0, 1'b0, 1'b1);
          4:    do_press(1'b0, 1'b1, 1'b1);
          default: begin
            if (fld < 3) do_press(1'b1, 1'b0, 1'b0);
            else         do_press(1'b0, 1'b0, 1'b1);
          end
        endcase
        check_state("rnd_op");
      end
      commit_from_field("rnd");
    end

    check("final_loads", 32'(load_cnt), 32'(exp_loads));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
